// File: rtl/hoplite_packet_assembler.sv
`default_nettype none
// =============================================================================
// hoplite_packet_assembler -- stages firmware field writes and queues packets
// toward the Hoplite injection port. Optional counter: HOPLITE_PACKET_COUNT_EN.
// Revision: 1.0
// =============================================================================
module hoplite_packet_assembler #(
  parameter int COORD_BITS           = 1,
  parameter int MULTICAST_GROUP_BITS = 1,
  parameter int MATRIX_TYPE_BITS     = 1,
  parameter int MATRIX_COORD_BITS    = 8,
  parameter int MATRIX_ELEMENT_BITS  = 32,
  parameter int FIFO_DEPTH_LOG2      = 2,
  parameter int PACKET_BITS          = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 +
                                       MATRIX_TYPE_BITS + 2*MATRIX_COORD_BITS +
                                       MATRIX_ELEMENT_BITS
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [COORD_BITS-1:0]           x_coord_in,
  input  logic                            x_coord_in_valid,
  input  logic [COORD_BITS-1:0]           y_coord_in,
  input  logic                            y_coord_in_valid,
  input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
  input  logic                            multicast_group_in_valid,
  input  logic                            done_flag_in,
  input  logic                            done_flag_in_valid,
  input  logic                            result_flag_in,
  input  logic                            result_flag_in_valid,
  input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
  input  logic                            matrix_type_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
  input  logic                            matrix_x_coord_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
  input  logic                            matrix_y_coord_in_valid,
  input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
  input  logic                            matrix_element_in_valid,
  input  logic                            packet_complete_in,
  output logic                            message_out_ready,
  output logic [PACKET_BITS-1:0]          packet_out,
  output logic                            packet_out_valid,
  input  logic                            packet_out_ready,
  output logic                            overflow_error,
  output logic [31:0]                     packets_sent
);

  localparam int c_depth = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] c_full_count = c_depth[FIFO_DEPTH_LOG2:0];

  logic [COORD_BITS-1:0]           r_x, r_y, w_x, w_y;
  logic [MULTICAST_GROUP_BITS-1:0] r_mcast, w_mcast;
  logic                            r_done, r_result, w_done, w_result;
  logic [MATRIX_TYPE_BITS-1:0]     r_type, w_type;
  logic [MATRIX_COORD_BITS-1:0]    r_mx, r_my, w_mx, w_my;
  logic [MATRIX_ELEMENT_BITS-1:0]  r_element, w_element;

  logic [PACKET_BITS-1:0]          r_mem [c_depth];
  logic [FIFO_DEPTH_LOG2-1:0]      r_wr_ptr, r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]        r_count;
  logic                            r_overflow;
  logic                            w_full, w_push, w_pop;
  logic [PACKET_BITS-1:0]          w_push_word;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_mcast   <= '0;
      r_done    <= 1'b0;
      r_result  <= 1'b0;
      r_type    <= '0;
      r_mx      <= '0;
      r_my      <= '0;
      r_element <= '0;
    end else begin
      if (x_coord_in_valid)         r_x       <= x_coord_in;
      if (y_coord_in_valid)         r_y       <= y_coord_in;
      if (multicast_group_in_valid) r_mcast   <= multicast_group_in;
      if (done_flag_in_valid)       r_done    <= done_flag_in;
      if (result_flag_in_valid)     r_result  <= result_flag_in;
      if (matrix_type_in_valid)     r_type    <= matrix_type_in;
      if (matrix_x_coord_in_valid)  r_mx      <= matrix_x_coord_in;
      if (matrix_y_coord_in_valid)  r_my      <= matrix_y_coord_in;
      if (matrix_element_in_valid)  r_element <= matrix_element_in;
    end
  end

  // A field written in the same cycle as packet_complete_in must land in that packet.
  assign w_x       = x_coord_in_valid         ? x_coord_in         : r_x;
  assign w_y       = y_coord_in_valid         ? y_coord_in         : r_y;
  assign w_mcast   = multicast_group_in_valid ? multicast_group_in : r_mcast;
  assign w_done    = done_flag_in_valid       ? done_flag_in       : r_done;
  assign w_result  = result_flag_in_valid     ? result_flag_in     : r_result;
  assign w_type    = matrix_type_in_valid     ? matrix_type_in     : r_type;
  assign w_mx      = matrix_x_coord_in_valid  ? matrix_x_coord_in  : r_mx;
  assign w_my      = matrix_y_coord_in_valid  ? matrix_y_coord_in  : r_my;
  assign w_element = matrix_element_in_valid  ? matrix_element_in  : r_element;

  assign w_push_word = {w_x, w_y, w_mcast, w_done, w_result, w_type, w_mx, w_my, w_element};

  assign w_full            = (r_count == c_full_count);
  assign packet_out_valid  = (r_count != '0);
  assign message_out_ready = !w_full;
  assign packet_out        = r_mem[r_rd_ptr];
  assign overflow_error    = r_overflow;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop  = packet_out_valid && packet_out_ready;
  assign w_push = packet_complete_in && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < c_depth; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_word;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (packet_complete_in && !w_push) r_overflow <= 1'b1;
    end
  end

`ifdef HOPLITE_PACKET_COUNT_EN
  logic [31:0] r_packets_sent;

  always_ff @(posedge clk) begin
    if (!reset_n)   r_packets_sent <= '0;
    else if (w_pop) r_packets_sent <= r_packets_sent + 32'd1;
  end

  assign packets_sent = r_packets_sent;
`else
  assign packets_sent = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hoplite_packet_assembler.sv
`default_nettype none
// Bench for hoplite_packet_assembler: table vectors, directed corner sequences and
// a queue-based scoreboard checked every cycle.
module tb_hoplite_packet_assembler;
  localparam int PB    = 54;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        x_coord_in, x_coord_in_valid, y_coord_in, y_coord_in_valid;
  logic        multicast_group_in, multicast_group_in_valid;
  logic        done_flag_in, done_flag_in_valid, result_flag_in, result_flag_in_valid;
  logic        matrix_type_in, matrix_type_in_valid;
  logic [7:0]  matrix_x_coord_in, matrix_y_coord_in;
  logic        matrix_x_coord_in_valid, matrix_y_coord_in_valid;
  logic [31:0] matrix_element_in;
  logic        matrix_element_in_valid;
  logic        packet_complete_in, message_out_ready;
  logic [PB-1:0] packet_out;
  logic        packet_out_valid, packet_out_ready, overflow_error;
  logic [31:0] packets_sent;

  hoplite_packet_assembler dut (
    .clk(clk), .reset_n(reset_n),
    .x_coord_in(x_coord_in), .x_coord_in_valid(x_coord_in_valid),
    .y_coord_in(y_coord_in), .y_coord_in_valid(y_coord_in_valid),
    .multicast_group_in(multicast_group_in), .multicast_group_in_valid(multicast_group_in_valid),
    .done_flag_in(done_flag_in), .done_flag_in_valid(done_flag_in_valid),
    .result_flag_in(result_flag_in), .result_flag_in_valid(result_flag_in_valid),
    .matrix_type_in(matrix_type_in), .matrix_type_in_valid(matrix_type_in_valid),
    .matrix_x_coord_in(matrix_x_coord_in), .matrix_x_coord_in_valid(matrix_x_coord_in_valid),
    .matrix_y_coord_in(matrix_y_coord_in), .matrix_y_coord_in_valid(matrix_y_coord_in_valid),
    .matrix_element_in(matrix_element_in), .matrix_element_in_valid(matrix_element_in_valid),
    .packet_complete_in(packet_complete_in), .message_out_ready(message_out_ready),
    .packet_out(packet_out), .packet_out_valid(packet_out_valid),
    .packet_out_ready(packet_out_ready), .overflow_error(overflow_error),
    .packets_sent(packets_sent)
  );

  typedef struct {
    logic [31:0] el;
    logic        cmp;
    logic        rdy;
    logic        exp_valid;
    logic        exp_mready;
    logic        exp_ovf;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [PB-1:0] exp_q[$];
  logic        m_x, m_y, m_mc, m_done, m_res, m_type, m_ovf;
  logic [7:0]  m_mx, m_my;
  logic [31:0] m_el, m_sent;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_sent();
`ifdef HOPLITE_PACKET_COUNT_EN
    return m_sent;
`else
    return 32'd0;
`endif
  endfunction

  task automatic idle();
    x_coord_in_valid = 0; y_coord_in_valid = 0; multicast_group_in_valid = 0;
    done_flag_in_valid = 0; result_flag_in_valid = 0; matrix_type_in_valid = 0;
    matrix_x_coord_in_valid = 0; matrix_y_coord_in_valid = 0; matrix_element_in_valid = 0;
    packet_complete_in = 0;
  endtask

  // Checks the cycle's outputs at the falling edge, advances the model, then steps
  // to 1 time unit past the next rising edge.
  task automatic tick();
    logic [PB-1:0] w;
    bit pop, push;
    @(negedge clk);
    if (!reset_n) begin
      exp_q.delete();
      {m_x, m_y, m_mc, m_done, m_res, m_type, m_ovf} = '0;
      m_mx = '0; m_my = '0; m_el = '0; m_sent = '0;
    end else begin
      check("valid", packet_out_valid, exp_q.size() != 0);
      check("msg_ready", message_out_ready, exp_q.size() < DEPTH);
      check("overflow", overflow_error, m_ovf);
      check("packets_sent", packets_sent, exp_sent());
      if (exp_q.size() != 0) check("head_packet", packet_out, exp_q[0]);
      pop = (exp_q.size() != 0) && packet_out_ready;
      w = {x_coord_in_valid ? x_coord_in : m_x,
           y_coord_in_valid ? y_coord_in : m_y,
           multicast_group_in_valid ? multicast_group_in : m_mc,
           done_flag_in_valid ? done_flag_in : m_done,
           result_flag_in_valid ? result_flag_in : m_res,
           matrix_type_in_valid ? matrix_type_in : m_type,
           matrix_x_coord_in_valid ? matrix_x_coord_in : m_mx,
           matrix_y_coord_in_valid ? matrix_y_coord_in : m_my,
           matrix_element_in_valid ? matrix_element_in : m_el};
      push = packet_complete_in && ((exp_q.size() < DEPTH) || pop);
      if (packet_complete_in && !push) m_ovf = 1'b1;
      if (pop) begin
        void'(exp_q.pop_front());
        m_sent = m_sent + 32'd1;
      end
      if (push) exp_q.push_back(w);
      if (x_coord_in_valid)         m_x    = x_coord_in;
      if (y_coord_in_valid)         m_y    = y_coord_in;
      if (multicast_group_in_valid) m_mc   = multicast_group_in;
      if (done_flag_in_valid)       m_done = done_flag_in;
      if (result_flag_in_valid)     m_res  = result_flag_in;
      if (matrix_type_in_valid)     m_type = matrix_type_in;
      if (matrix_x_coord_in_valid)  m_mx   = matrix_x_coord_in;
      if (matrix_y_coord_in_valid)  m_my   = matrix_y_coord_in;
      if (matrix_element_in_valid)  m_el   = matrix_element_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle();
    tick();
    reset_n = 1;
    check("rst_valid", packet_out_valid, 1'b0);
    check("rst_msg_ready", message_out_ready, 1'b1);
    check("rst_packet", packet_out, '0);
    check("rst_overflow", overflow_error, 1'b0);
    check("rst_packets_sent", packets_sent, 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[10];
    logic [PB-1:0] p1, p2;
    vecs[0] = '{32'hA0, 1, 0, 0, 1, 0};
    vecs[1] = '{32'hA1, 1, 0, 1, 1, 0};
    vecs[2] = '{32'hA2, 1, 0, 1, 1, 0};
    vecs[3] = '{32'hA3, 1, 0, 1, 1, 0};
    vecs[4] = '{32'hA4, 1, 0, 1, 0, 0};
    vecs[5] = '{32'h0,  0, 1, 1, 0, 1};
    vecs[6] = '{32'h0,  0, 1, 1, 1, 1};
    vecs[7] = '{32'h0,  0, 1, 1, 1, 1};
    vecs[8] = '{32'h0,  0, 1, 1, 1, 1};
    vecs[9] = '{32'h0,  0, 0, 0, 1, 1};
    p1 = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'hDEADBEEF};
    p2 = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h00000005};

    {x_coord_in, y_coord_in, multicast_group_in, done_flag_in, result_flag_in, matrix_type_in} = '0;
    matrix_x_coord_in = '0; matrix_y_coord_in = '0; matrix_element_in = '0;
    packet_out_ready = 0;
    reset_n = 0;
    idle();
    tick();
    do_reset();

    // Field writes then complete, router stalled.
    x_coord_in = 1; x_coord_in_valid = 1;
    y_coord_in = 0; y_coord_in_valid = 1;
    matrix_element_in = 32'hDEADBEEF; matrix_element_in_valid = 1;
    tick();
    idle();
    packet_complete_in = 1;
    tick();
    idle();
    check("t1_valid", packet_out_valid, 1'b1);
    check("t1_packet", packet_out, p1);

    // Two packets in order, second differs only in element.
    packet_out_ready = 1;
    tick();
    packet_complete_in = 1;
    tick();
    idle();
    check("t2_first", packet_out, p1);
    matrix_element_in = 32'h5; matrix_element_in_valid = 1;
    tick();
    idle();
    packet_complete_in = 1;
    tick();
    idle();
    check("t2_second", packet_out, p2);
    tick();

    // Fill, overflow, drain.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
      matrix_element_in       = vecs[i].el;
      matrix_element_in_valid = vecs[i].cmp;
      packet_complete_in      = vecs[i].cmp;
      packet_out_ready        = vecs[i].rdy;
      check($sformatf("vec%0d_valid", i), packet_out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_msg_ready", i), message_out_ready, vecs[i].exp_mready);
      check($sformatf("vec%0d_overflow", i), overflow_error, vecs[i].exp_ovf);
      tick();
    end
    idle();

    // Full FIFO with same-cycle push and pop.
    do_reset();
    packet_out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      matrix_element_in = 32'hB0 + i; matrix_element_in_valid = 1; packet_complete_in = 1;
      tick();
    end
    matrix_element_in = 32'hB4; matrix_element_in_valid = 1; packet_complete_in = 1;
    packet_out_ready = 1;
    check("t4_full_ready", message_out_ready, 1'b0);
    tick();
    idle();
    packet_out_ready = 0;
    check("t4_still_full", message_out_ready, 1'b0);
    check("t4_no_overflow", overflow_error, 1'b0);
    packet_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_drain%0d", i), packet_out[31:0], 32'hB1 + i);
      tick();
    end
    packet_out_ready = 0;

    // Matrix column written in the complete cycle.
    matrix_x_coord_in = 8'd7; matrix_x_coord_in_valid = 1; packet_complete_in = 1;
    tick();
    idle();
    check("t5_mx", packet_out[47:40], 8'd7);

    // Reset with three queued packets, then count three pops.
    packet_complete_in = 1;
    tick();
    tick();
    idle();
    check("t6_three_queued", message_out_ready && packet_out_valid, 1'b1);
    do_reset();
    packet_complete_in = 1;
    for (int i = 0; i < 3; i++) tick();
    idle();
    packet_out_ready = 1;
    for (int i = 0; i < 3; i++) tick();
`ifdef HOPLITE_PACKET_COUNT_EN
    check("t6_packets_sent", packets_sent, 32'd3);
`else
    check("t6_packets_sent", packets_sent, 32'd0);
`endif

    // Random traffic over every field.
    for (int i = 0; i < 300; i++) begin
      idle();
      x_coord_in = 1'($urandom);         x_coord_in_valid = ($urandom_range(2) == 0);
      y_coord_in = 1'($urandom);         y_coord_in_valid = ($urandom_range(2) == 0);
      multicast_group_in = 1'($urandom); multicast_group_in_valid = ($urandom_range(2) == 0);
      done_flag_in = 1'($urandom);       done_flag_in_valid = ($urandom_range(2) == 0);
      result_flag_in = 1'($urandom);     result_flag_in_valid = ($urandom_range(2) == 0);
      matrix_type_in = 1'($urandom);     matrix_type_in_valid = ($urandom_range(2) == 0);
      matrix_x_coord_in = 8'($urandom);  matrix_x_coord_in_valid = ($urandom_range(2) == 0);
      matrix_y_coord_in = 8'($urandom);  matrix_y_coord_in_valid = ($urandom_range(2) == 0);
      matrix_element_in = $urandom;      matrix_element_in_valid = ($urandom_range(2) == 0);
      packet_complete_in = 1'($urandom);
      packet_out_ready = 1'($urandom);
      tick();
    end
    idle();
    packet_out_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    check("final_drained", packet_out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
